// File: rtl/lcd_char_ctrl.sv
`timescale 1ns/1ps
// lcd_char_ctrl
// HD44780 character-LCD controller. After reset it runs the power-on wait and
// the fixed initialisation byte sequence. It then accepts characters over a
// valid/ready handshake and writes them to DDRAM, tracking the cursor over
// ROWS x COLS. When the cursor runs off the end of a row, it moves the DDRAM
// address to the start of the next row (wrapping to row 0 after the last).
// Command completion uses either fixed execution delays or busy-flag polling
// (USE_BF).
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   wr_valid/wr_data/wr_ready   character stream (valid/ready)
//   clr_req         one-cycle clear-display + home request (idle only)
//   init_done       sticky, initialisation sequence finished
//   bf_timeout      sticky, a busy-flag poll ran out of time
//   LCD_DATA        DB7..DB0, driven while LCD_RW=0, released while LCD_RW=1
//   LCD_EN/RS/RW    bus strobes
//   LCD_ON          panel power (always on)
//   LCD_BLON        backlight, on once initialisation is done
module lcd_char_ctrl #(
   parameter int CLK_HZ        = 50_000_000,
   parameter int COLS          = 16,
   parameter int ROWS          = 2,
   parameter bit USE_BF        = 1'b0,
   parameter int EN_US         = 1,
   parameter int BF_TIMEOUT_US = 5000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_valid,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   input  logic       clr_req,
   output logic       init_done,
   output logic       bf_timeout,
   inout  wire  [7:0] LCD_DATA,
   output logic       LCD_EN,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_ON,
   output logic       LCD_BLON
);

   localparam int          T_US     = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
   localparam int          EN_CYC   = (EN_US * T_US < 1) ? 1 : EN_US * T_US;
   localparam logic [31:0] PWR_CYC  = 32'(15000 * T_US);
   localparam logic [31:0] CMD_CYC  = 32'(50 * T_US);
   localparam logic [31:0] CLR_CYC  = 32'(2000 * T_US);
   localparam logic [31:0] BF_LIM   = (BF_TIMEOUT_US * T_US < 1) ? 32'd1
                                                                 : 32'(BF_TIMEOUT_US * T_US);
   localparam logic [7:0]  FN_SET   = (ROWS >= 2) ? 8'h38 : 8'h30;
   localparam logic [5:0]  COL_LAST = 6'(COLS - 1);
   localparam logic [1:0]  ROW_LAST = 2'(ROWS - 1);

   typedef enum logic [2:0] {
      S_PWR, S_INIT, S_IDLE, S_SETUP, S_EN_HI, S_EN_LO, S_EXEC, S_BF
   } state_t;

   function automatic logic [7:0] init_byte(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: init_byte = 8'h30;
         3'd3:             init_byte = FN_SET;
         3'd4:             init_byte = 8'h0C;
         3'd5:             init_byte = 8'h01;
         default:          init_byte = 8'h06;
      endcase
   endfunction

   function automatic logic [31:0] init_wait(input logic [2:0] idx);
      case (idx)
         3'd0:       init_wait = 32'(4100 * T_US);
         3'd1, 3'd2: init_wait = 32'(100 * T_US);
         3'd5:       init_wait = CLR_CYC;
         default:    init_wait = CMD_CYC;
      endcase
   endfunction

   function automatic logic [7:0] row_base(input logic [1:0] row);
      case (row)
         2'd0:    row_base = 8'h00;
         2'd1:    row_base = 8'h40;
         2'd2:    row_base = 8'h14;
         default: row_base = 8'h54;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] tgt;
   logic        tdone;
   logic [2:0]  init_idx_q, init_idx_d;
   logic        init_done_q, init_done_d;
   logic        bf_to_q, bf_to_d;
   logic        rs_q, rs_d;
   logic        rw_q, rw_d;
   logic        rd_q, rd_d;          // current bus cycle is a busy-flag read
   logic [7:0]  dat_q, dat_d;
   logic        pend_q, pend_d;      // set-DDRAM command queued after a wrap
   logic [7:0]  pend_dat_q, pend_dat_d;
   logic [1:0]  row_q, row_d, row_nx;
   logic [5:0]  col_q, col_d;
   logic [31:0] wait_q, wait_d;
   logic        busy_q, busy_d;
   logic [31:0] bf_cnt_q, bf_cnt_d;
   logic        done_cmd;
   logic        go_init;
   logic [2:0]  init_sel;

   // Per-state dwell time; every state not listed lasts one cycle.
   always_comb begin
      tgt = 32'd1;
      case (state_q)
         S_PWR:            tgt = PWR_CYC;
         S_EN_HI, S_EN_LO: tgt = 32'(EN_CYC);
         S_EXEC:           tgt = wait_q;
         default:          tgt = 32'd1;
      endcase
   end

   assign tdone = (cnt_q >= tgt - 32'd1);

   always_comb begin
      state_d     = state_q;
      init_idx_d  = init_idx_q;
      init_done_d = init_done_q;
      bf_to_d     = bf_to_q;
      rs_d        = rs_q;
      rw_d        = rw_q;
      rd_d        = rd_q;
      dat_d       = dat_q;
      pend_d      = pend_q;
      pend_dat_d  = pend_dat_q;
      row_d       = row_q;
      col_d       = col_q;
      wait_d      = wait_q;
      busy_d      = busy_q;
      bf_cnt_d    = bf_cnt_q;
      done_cmd    = 1'b0;
      go_init     = 1'b0;
      init_sel    = init_idx_q;
      row_nx      = (row_q == ROW_LAST) ? 2'd0 : row_q + 2'd1;

      // Poll time accumulates across repeated reads of one command.
      if (rd_q && (state_q == S_BF || state_q == S_EN_HI || state_q == S_EN_LO)
          && bf_cnt_q < BF_LIM)
         bf_cnt_d = bf_cnt_q + 32'd1;

      case (state_q)
         S_PWR: begin
            if (tdone) begin
               go_init  = 1'b1;
               init_sel = 3'd0;
            end
         end
         // S_INIT is the setup cycle of an init command (bus valid, EN low).
         S_INIT:  state_d = S_EN_HI;
         S_IDLE: begin
            if (clr_req) begin
               rs_d    = 1'b0;
               rw_d    = 1'b0;
               rd_d    = 1'b0;
               dat_d   = 8'h01;
               wait_d  = CLR_CYC;
               row_d   = 2'd0;
               col_d   = 6'd0;
               state_d = S_SETUP;
            end else if (wr_valid) begin
               rs_d    = 1'b1;
               rw_d    = 1'b0;
               rd_d    = 1'b0;
               dat_d   = wr_data;
               wait_d  = CMD_CYC;
               state_d = S_SETUP;
               if (col_q == COL_LAST) begin
                  col_d      = 6'd0;
                  row_d      = row_nx;
                  pend_d     = 1'b1;
                  pend_dat_d = 8'h80 | row_base(row_nx);
               end else begin
                  col_d = col_q + 6'd1;
               end
            end
         end
         S_SETUP: state_d = S_EN_HI;
         S_BF:    state_d = S_EN_HI;
         S_EN_HI: begin
            if (tdone) begin
               if (rd_q)
                  busy_d = LCD_DATA[7];
               state_d = S_EN_LO;
            end
         end
         S_EN_LO: begin
            if (tdone) begin
               if (rd_q) begin
                  if (!busy_q) begin
                     done_cmd = 1'b1;
                  end else if (bf_cnt_q + 32'd1 >= BF_LIM) begin
                     bf_to_d  = 1'b1;
                     done_cmd = 1'b1;
                  end else begin
                     state_d = S_BF;
                  end
               end else if (USE_BF && init_done_q) begin
                  // Release DATA and raise RW on the same edge.
                  rd_d     = 1'b1;
                  rw_d     = 1'b1;
                  rs_d     = 1'b0;
                  bf_cnt_d = 32'd0;
                  state_d  = S_BF;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC:  if (tdone) done_cmd = 1'b1;
         default: state_d = S_PWR;
      endcase

      if (done_cmd) begin
         if (pend_q) begin
            pend_d  = 1'b0;
            rs_d    = 1'b0;
            rw_d    = 1'b0;
            rd_d    = 1'b0;
            dat_d   = pend_dat_q;
            wait_d  = CMD_CYC;
            state_d = S_SETUP;
         end else if (!init_done_q) begin
            if (init_idx_q == 3'd6) begin
               init_done_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               init_idx_d = init_idx_q + 3'd1;
               go_init    = 1'b1;
               init_sel   = init_idx_q + 3'd1;
            end
         end else begin
            state_d = S_IDLE;
         end
      end

      if (go_init) begin
         rs_d    = 1'b0;
         rw_d    = 1'b0;
         rd_d    = 1'b0;
         dat_d   = init_byte(init_sel);
         wait_d  = init_wait(init_sel);
         state_d = S_INIT;
      end

      // Counter restarts on every state entry and saturates at the target.
      if (state_d != state_q)
         cnt_d = 32'd0;
      else if (cnt_q < tgt)
         cnt_d = cnt_q + 32'd1;
      else
         cnt_d = cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_PWR;
         cnt_q       <= 32'd0;
         init_idx_q  <= 3'd0;
         init_done_q <= 1'b0;
         bf_to_q     <= 1'b0;
         rs_q        <= 1'b0;
         rw_q        <= 1'b0;
         rd_q        <= 1'b0;
         dat_q       <= 8'h00;
         pend_q      <= 1'b0;
         row_q       <= 2'd0;
         col_q       <= 6'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_idx_q  <= init_idx_d;
         init_done_q <= init_done_d;
         bf_to_q     <= bf_to_d;
         rs_q        <= rs_d;
         rw_q        <= rw_d;
         rd_q        <= rd_d;
         dat_q       <= dat_d;
         pend_q      <= pend_d;
         row_q       <= row_d;
         col_q       <= col_d;
      end
   end

   always_ff @(posedge clk) begin
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      bf_cnt_q   <= bf_cnt_d;
      pend_dat_q <= pend_dat_d;
   end

   assign wr_ready   = (state_q == S_IDLE) & init_done_q & ~clr_req;
   assign init_done  = init_done_q;
   assign bf_timeout = bf_to_q;
   assign LCD_EN     = (state_q == S_EN_HI);
   assign LCD_RS     = rs_q;
   assign LCD_RW     = rw_q;
   assign LCD_DATA   = rw_q ? 8'hzz : dat_q;
   assign LCD_ON     = 1'b1;
   assign LCD_BLON   = init_done_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
`timescale 1ns/1ps
// Bench for lcd_char_ctrl: dut0 uses fixed delays, dut1 polls the busy flag.
// Both run at 1 MHz (1 cycle per us) with COLS=4, ROWS=2, EN_US=1.
module tb_lcd_char_ctrl;

   localparam int COLS_T = 4;
   localparam int ROWS_T = 2;
   localparam int EN_C   = 1;
   localparam int CHR_C  = 1 + 2 * EN_C + 50;
   localparam int CLR_C  = 1 + 2 * EN_C + 2000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1;
   logic       wr_valid0, wr_valid1, clr_req0, clr_req1;
   logic [7:0] wr_data0, wr_data1;
   logic       rdy0, rdy1, idone0, idone1, bft0, bft1;
   logic       en0, rs0, rw0, on0, blon0;
   logic       en1, rs1, rw1, on1, blon1;
   wire  [7:0] lcd_data0, lcd_data1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Behavioural model state
   logic [9:0] exp0[$];
   logic [9:0] mon0[$];
   logic [9:0] mon1[$];
   int         t0[$];
   int         row = 0, col = 0;
   int         base[4] = '{32'h00, 32'h40, 32'h14, 32'h54};
   int         rd_tot1 = 0, rd_base1 = 0, busy_polls = 0;
   logic [7:0] rd_last1 = 8'h00;
   logic       en0_prev = 1'b0, en1_prev = 1'b0;
   logic       db7_1;

   // LCD model for dut1: answers reads with DB7 busy for the first busy_polls reads.
   assign db7_1     = ((rd_tot1 - rd_base1) <= busy_polls);
   assign lcd_data1 = rw1 ? {db7_1, 7'h15} : 8'hzz;

   lcd_char_ctrl #(.CLK_HZ(1_000_000), .COLS(COLS_T), .ROWS(ROWS_T), .USE_BF(1'b0),
                   .EN_US(1), .BF_TIMEOUT_US(5000)) dut0 (
      .clk(clk), .reset(rst0), .wr_valid(wr_valid0), .wr_data(wr_data0),
      .wr_ready(rdy0), .clr_req(clr_req0), .init_done(idone0), .bf_timeout(bft0),
      .LCD_DATA(lcd_data0), .LCD_EN(en0), .LCD_RS(rs0), .LCD_RW(rw0),
      .LCD_ON(on0), .LCD_BLON(blon0));

   lcd_char_ctrl #(.CLK_HZ(1_000_000), .COLS(COLS_T), .ROWS(ROWS_T), .USE_BF(1'b1),
                   .EN_US(1), .BF_TIMEOUT_US(5000)) dut1 (
      .clk(clk), .reset(rst1), .wr_valid(wr_valid1), .wr_data(wr_data1),
      .wr_ready(rdy1), .clr_req(clr_req1), .init_done(idone1), .bf_timeout(bft1),
      .LCD_DATA(lcd_data1), .LCD_EN(en1), .LCD_RS(rs1), .LCD_RW(rw1),
      .LCD_ON(on1), .LCD_BLON(blon1));

   always @(posedge clk) cyc++;

   // Bus monitor: log every EN rising edge.
   always @(negedge clk) begin
      if (en0 && !en0_prev) begin
         mon0.push_back({rs0, rw0, lcd_data0});
         t0.push_back(cyc);
      end
      en0_prev = en0;
      if (en1 && !en1_prev) begin
         if (rw1) begin
            rd_tot1++;
            rd_last1 = lcd_data1;
         end else begin
            mon1.push_back({rs1, rw1, lcd_data1});
         end
      end
      en1_prev = en1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_rdy0(output int n);
      n = 0;
      while (!rdy0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
   endtask

   // One transaction on dut0, with the model updated from the cursor rules.
   task automatic send0(input bit clr, input bit chr, input logic [7:0] d);
      int n;
      bit wrap;
      wait_rdy0(n);
      chk("rdy_before_op", rdy0, 1'b1);
      clr_req0  = clr;
      wr_valid0 = chr;
      wr_data0  = d;
      if (clr) begin
         #1 chk("rdy_masked_by_clr", rdy0, 1'b0);
         @(negedge clk);
         clr_req0 = 1'b0;
         exp0.push_back(10'h001);
         row = 0;
         col = 0;
         wait_rdy0(n);
         chk("clr_busy_cycles", n, CLR_C);
      end
      if (chr) begin
         @(negedge clk);
         wr_valid0 = 1'b0;
         exp0.push_back({1'b1, 1'b0, d});
         col++;
         wrap = 1'b0;
         if (col == COLS_T) begin
            col  = 0;
            row  = (row + 1) % ROWS_T;
            wrap = 1'b1;
            exp0.push_back(10'h080 | 10'(base[row]));
         end
         wait_rdy0(n);
         chk(wrap ? "chr_wrap_busy_cycles" : "chr_busy_cycles", n, wrap ? 2 * CHR_C : CHR_C);
      end
   endtask

   initial begin
      int         n, start, k, minsp;
      logic [7:0] c;
      int         iwait[6] = '{4100, 100, 100, 50, 50, 2000};
      logic [7:0] ibyte[7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};

      rst0 = 1'b1; rst1 = 1'b1;
      wr_valid0 = 1'b0; wr_valid1 = 1'b0; clr_req0 = 1'b0; clr_req1 = 1'b0;
      wr_data0 = 8'h00; wr_data1 = 8'h00;
      repeat (3) @(negedge clk);

      chk("rst_en", en0, 1'b0);
      chk("rst_rs", rs0, 1'b0);
      chk("rst_rw", rw0, 1'b0);
      chk("rst_data", lcd_data0, 8'h00);
      chk("rst_on", on0, 1'b1);
      chk("rst_blon", blon0, 1'b0);
      chk("rst_rdy", rdy0, 1'b0);
      chk("rst_init_done", idone0, 1'b0);
      chk("rst_bf_timeout", bft0, 1'b0);

      rst0 = 1'b0; rst1 = 1'b0;
      start = cyc;
      n = 0;
      while (!idone0 && n < 40000) begin
         @(negedge clk);
         n++;
      end
      chk("init_done_seen", idone0, 1'b1);
      chk("init_blon", blon0, 1'b1);
      chk("init_writes", mon0.size(), 7);
      if (mon0.size() >= 7) begin
         k = t0[0] - start;
         chk($sformatf("first_en_cycle_%0d_in_15000_15002", k), (k >= 15000 && k <= 15002), 1'b1);
         for (int i = 0; i < 7; i++)
            chk($sformatf("init_byte%0d", i), mon0[i], {2'b00, ibyte[i]});
         for (int i = 0; i < 6; i++) begin
            k = t0[i + 1] - t0[i];
            chk($sformatf("init_gap%0d_%0d", i, k), (k >= iwait[i] && k <= iwait[i] + 5), 1'b1);
         end
         k = cyc - t0[6];
         chk($sformatf("init_done_after_06_%0d", k), (k >= 50 && k <= 53), 1'b1);
      end

      // Busy-flag mode: no reads during init, then 3 busy polls + 1 ready poll.
      chk("bf_init_done", idone1, 1'b1);
      chk("bf_no_poll_in_init", rd_tot1, 0);
      busy_polls = 3;
      rd_base1   = rd_tot1;
      wr_valid1  = 1'b1;
      wr_data1   = 8'h5A;
      @(negedge clk);
      wr_valid1 = 1'b0;
      n = 0;
      while (!rdy1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("bf_back_idle", rdy1, 1'b1);
      chk("bf_read_cycles", rd_tot1 - rd_base1, 4);
      chk("bf_no_timeout", bft1, 1'b0);
      if (mon1.size() > 0)
         chk("bf_char_write", mon1[mon1.size() - 1], {1'b1, 1'b0, 8'h5A});
      else
         chk("bf_char_write_count", mon1.size(), 8);

      // Busy flag stuck high: timeout after 5000 us, then back to idle.
      busy_polls = 32'h7fff_ffff;
      rd_base1   = rd_tot1;
      wr_valid1  = 1'b1;
      wr_data1   = 8'h21;
      @(negedge clk);
      wr_valid1 = 1'b0;
      n = 0;
      while (!rdy1 && n < 12000) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("bf_timeout_busy_%0d_in_5000_5010", n), (n >= 5000 && n <= 5010), 1'b1);
      chk("bf_timeout_flag", bft1, 1'b1);
      chk("bf_bus_released_value", rd_last1, 8'h95);

      // Directed: "AB", then clear and char in the same cycle.
      send0(1'b0, 1'b1, 8'h41);
      send0(1'b0, 1'b1, 8'h42);
      send0(1'b1, 1'b1, 8'h43);
      // Random traffic exercising wraps and clears.
      for (int i = 0; i < 20; i++) begin
         k = $urandom_range(0, 9);
         c = 8'($urandom);
         if (k == 0)      send0(1'b1, 1'b0, c);
         else if (k == 1) send0(1'b1, 1'b1, c);
         else             send0(1'b0, 1'b1, c);
      end
      @(negedge clk);
      chk("wr_count", mon0.size() - 7, exp0.size());
      for (int i = 0; i < exp0.size() && i + 7 < mon0.size(); i++)
         chk($sformatf("wr%0d", i), mon0[i + 7], exp0[i]);
      minsp = 1000000;
      for (int i = 1; i < t0.size(); i++)
         if (t0[i] - t0[i - 1] < minsp) minsp = t0[i] - t0[i - 1];
      chk($sformatf("min_en_spacing_%0d", minsp), (minsp >= 2 * EN_C), 1'b1);

      // Reset while EN is high during a character write.
      wait_rdy0(n);
      wr_valid0 = 1'b1;
      wr_data0  = 8'h33;
      @(negedge clk);
      wr_valid0 = 1'b0;
      n = 0;
      while (!en0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("en_hi_before_rst", en0, 1'b1);
      rst0 = 1'b1;
      @(negedge clk);
      chk("mid_rst_en", en0, 1'b0);
      chk("mid_rst_rs", rs0, 1'b0);
      chk("mid_rst_rw", rw0, 1'b0);
      chk("mid_rst_data", lcd_data0, 8'h00);
      chk("mid_rst_blon", blon0, 1'b0);
      chk("mid_rst_init_done", idone0, 1'b0);
      chk("mid_rst_rdy", rdy0, 1'b0);
      mon0.delete();
      t0.delete();
      rst0  = 1'b0;
      start = cyc;
      n = 0;
      while (mon0.size() == 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("restart_en_seen", (mon0.size() > 0), 1'b1);
      if (mon0.size() > 0) begin
         k = t0[0] - start;
         chk($sformatf("restart_en_cycle_%0d_in_15000_15002", k), (k >= 15000 && k <= 15002), 1'b1);
         chk("restart_first_byte", mon0[0], 10'h030);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #950_000;
      $display("FAIL watchdog cycles=%0d limit=95000", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
